pi_controller64_water: RTL and testbench
========================================

// Module: pi_controller64_water
// PURPOSE
//  Discrete PI regulator for the water-turbine governor loop; directly upstream of the 64-bit limit control stage.
//  Per sta pulse: integ <= integ + ki_ts*e; u <= kp*e + integ(new). u feeds the limiter x input, done_sig feeds its sta.
//  Sequences shared double-precision multiplier/adder IP through a small FSM with a start/done handshake.
// PARAMETERS
//  MUL_LAT  6  pipeline latency (clk) of FloatMult_64
//  ADD_LAT  7  pipeline latency (clk) of FloatAddSub_64
//  CMP_LAT  1  latency of FloatComparator_64 (used only with PI_INTEG_CLAMP_EN)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-low
//  sta          in   1   start pulse; e, kp, ki_ts sampled this cycle
//  init         in   1   load integrator with init_val (IDLE only)
//  init_val     in   64  integrator preload, IEEE-754 double
//  kp           in   64  proportional gain
//  ki_ts        in   64  integral gain times step Ts
//  e            in   64  error input
//  integ_hi     in   64  integrator upper clamp (PI_INTEG_CLAMP_EN only)
//  integ_lo     in   64  integrator lower clamp (PI_INTEG_CLAMP_EN only)
//  u            out  64  controller output, held between updates
//  integ        out  64  integrator state
//  busy         out  1   high from cycle after accepted sta until done_sig
//  done_sig     out  1   one-cycle pulse when u/integ updated
// BEHAVIOUR
//  Reset (rst=0, async): u=0, integ=0, busy=0, done_sig=0, FSM=IDLE; IP aclr driven by ~rst. Reset mid-op aborts, no done_sig.
//  States: IDLE -> MUL (MUL_LAT cyc, kp*e and ki_ts*e on two multipliers in parallel)
//          -> ADD_I (ADD_LAT, integ + ki_e) [-> CLAMP when enabled] -> ADD_U (ADD_LAT, kp_e + integ_new) -> DONE -> IDLE.
//  Latency cycle counter per state; counter reloads on each transition. IP clk_en tied to `ena_math.
//  sta accepted only in IDLE; sta while busy ignored (not queued). init in IDLE: integ<=init_val next cycle, no done_sig.
//  init and sta same cycle: init wins, sta dropped. init while busy ignored.
//  integ register written at end of ADD_I (or CLAMP); u and done_sig written in DONE, same edge.
//  Total sta->done_sig latency: 1 + MUL_LAT + 2*ADD_LAT + 1 cycles (=22 at defaults), + CMP_LAT + 1 with clamp.
//  All data `EXTENDED_SINGLE (64) bits, IEEE-754 double; no NaN/Inf handling beyond IP behaviour.
//  Inputs kp, ki_ts, e captured into registers on accepted sta; later changes do not affect the running update.
// CONFIGURATION
//  PI_INTEG_CLAMP_EN defined: CLAMP state after ADD_I; two FloatComparator_64 compare integ_new with integ_hi/integ_lo;
//   >hi -> integ_hi, <lo -> integ_lo, else unchanged (anti-windup). Latency +CMP_LAT+1.
//  Undefined: no CLAMP state, no comparators; integ_hi/integ_lo ports present but unused.
// STRUCTURE
//  Shared package/global_parameter.v: `EXTENDED_SINGLE, `ena_math, FSM state encodings (PI_ST_IDLE..PI_ST_DONE),
//   default latency constants.
//  Sub-module: pi_latency_cnt (loadable down-counter, terminal-count flag) instantiated once; IP cores instantiated directly.
// TESTING
//  Default build, kp=2.0 (4000000000000000), ki_ts=0.5 (3FE0000000000000), e=1.0 (3FF0000000000000), integ=0:
//   sta -> done_sig exactly 22 cyc later, integ=3FE0000000000000, u=4004000000000000 (2.5).
//  Second sta same inputs -> integ=3FF0000000000000 (1.0), u=4008000000000000 (3.0).
//  init=1 init_val=C000000000000000 (-2.0), then sta e=1.0 -> integ=BFF8000000000000 (-1.5), u=3FE0000000000000 (0.5).
//  sta pulsed at cycles +3 and +10 while busy -> ignored, single done_sig, busy high 22 cyc; init+sta together -> only preload.
//  rst low at cycle +8 of an update -> u=0, integ=0, busy=0 immediately, no done_sig; next sta completes normally.
//  PI_INTEG_CLAMP_EN, integ_hi=3FF0000000000000, integ=3FF0000000000000, e=1.0 -> integ stays 1.0, u=4008000000000000,
//   latency 24.

Source files
------------

// File: rtl/pi_controller64_water_pkg.sv
// pi_controller64_water_pkg: data width, IP clock enable, default IP latencies,
// FSM state encodings and the latency-counter reload helper.
// Optional feature macro used by the design: PI_INTEG_CLAMP_EN (integrator anti-windup clamp).
`ifndef EXTENDED_SINGLE
`define EXTENDED_SINGLE 64
`endif
`ifndef ENA_MATH
`define ENA_MATH 1'b1
`endif

package pi_controller64_water_pkg;
    localparam int MUL_LAT_DEF = 6;
    localparam int ADD_LAT_DEF = 7;
    localparam int CMP_LAT_DEF = 1;
    localparam int CNT_W       = 8;

    typedef enum logic [2:0] {
        PI_ST_IDLE  = 3'd0,
        PI_ST_MUL   = 3'd1,
        PI_ST_ADD_I = 3'd2,
        PI_ST_CLAMP = 3'd3,
        PI_ST_ADD_U = 3'd4,
        PI_ST_DONE  = 3'd5
    } pi_state_e;

    // a state lasting n cycles loads n-1; terminal count fires in its last cycle
    function automatic logic [CNT_W-1:0] lat_reload(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction
endpackage

// File: rtl/pi_controller64_water_cnt.sv
// pi_latency_cnt: loadable down-counter with terminal-count flag, paces FSM states.
module pi_latency_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    // reload on state transition, otherwise count down and rest at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)          r_cnt <= '0;
        else if (i_load)       r_cnt <= i_load_val;
        else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end

    assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/pi_controller64_water_fpu.sv
// Double-precision arithmetic cores: multiplier, adder/subtractor, comparator.
// Normal numbers only (denormals flush to zero), round-to-nearest-even, LAT-deep
// output pipeline so the sequencing FSM sees the documented latencies.
module FloatMult_64 #(
    parameter int LAT = 6
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [63:0] dataa,
    input  logic [63:0] datab,
    output logic [63:0] result
);
    function automatic logic [63:0] f_mul(input logic [63:0] a, input logic [63:0] b);
        logic [105:0]       p;
        logic [52:0]        m;
        logic [53:0]        mr;
        logic               g, st, sg;
        logic signed [12:0] ee;
        sg = a[63] ^ b[63];
        if (a[62:52] == 11'd0 || b[62:52] == 11'd0) return {sg, 63'd0};
        p  = {1'b1, a[51:0]} * {1'b1, b[51:0]};
        ee = $signed({2'b00, a[62:52]}) + $signed({2'b00, b[62:52]}) - 13'sd1023;
        if (p[105]) begin
            m = p[105:53]; g = p[52]; st = |p[51:0]; ee = ee + 13'sd1;
        end else begin
            m = p[104:52]; g = p[51]; st = |p[50:0];
        end
        mr = {1'b0, m} + {53'd0, g & (st | m[0])};
        if (mr[53]) begin
            mr = mr >> 1; ee = ee + 13'sd1;
        end
        if (ee <= 13'sd0)    return {sg, 63'd0};
        if (ee >= 13'sd2047) return {sg, 11'h7FF, 52'd0};
        return {sg, ee[10:0], mr[51:0]};
    endfunction

    logic [LAT-1:0][63:0] r_pipe;

    // result pipeline
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) r_pipe <= '0;
        else if (clk_en) begin
            r_pipe[0] <= f_mul(dataa, datab);
            for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign result = r_pipe[LAT-1];
endmodule

module FloatAddSub_64 #(
    parameter int LAT = 7
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        add_sub,
    input  logic [63:0] dataa,
    input  logic [63:0] datab,
    output logic [63:0] result
);
    // x must have the larger magnitude
    function automatic logic [63:0] f_add(input logic [63:0] x, input logic [63:0] y);
        logic [11:0]        d;
        logic [55:0]        mx, my, sh;
        logic [56:0]        s;
        logic signed [12:0] ee;
        logic [53:0]        mr;
        logic               rnd;
        if (x[62:52] == 11'd0) return '0;
        if (y[62:52] == 11'd0) return x;
        mx = {1'b1, x[51:0], 3'b000};
        my = {1'b1, y[51:0], 3'b000};
        d  = {1'b0, x[62:52]} - {1'b0, y[62:52]};
        if (d >= 12'd56) sh = {55'd0, 1'b1};
        else             sh = (my >> d) | {55'd0, |(my & ~({56{1'b1}} << d))};
        s = (x[63] ^ y[63]) ? ({1'b0, mx} - {1'b0, sh}) : ({1'b0, mx} + {1'b0, sh});
        if (s == 57'd0) return '0;
        ee = $signed({2'b00, x[62:52]});
        if (s[56]) begin
            s = {1'b0, s[56:2], s[1] | s[0]}; ee = ee + 13'sd1;
        end
        for (int i = 0; i < 56; i++) begin
            if (!s[55]) begin
                s = s << 1; ee = ee - 13'sd1;
            end
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        mr  = {1'b0, s[55:3]} + {53'd0, rnd};
        if (mr[53]) begin
            mr = mr >> 1; ee = ee + 13'sd1;
        end
        if (ee <= 13'sd0)    return '0;
        if (ee >= 13'sd2047) return {x[63], 11'h7FF, 52'd0};
        return {x[63], ee[10:0], mr[51:0]};
    endfunction

    logic [63:0]          w_b, w_res;
    logic [LAT-1:0][63:0] r_pipe;

    // order operands by magnitude before the shared add path
    always_comb begin
        w_b = {datab[63] ^ ~add_sub, datab[62:0]};
        if (w_b[62:0] > dataa[62:0]) w_res = f_add(w_b, dataa);
        else                         w_res = f_add(dataa, w_b);
    end

    // result pipeline
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) r_pipe <= '0;
        else if (clk_en) begin
            r_pipe[0] <= w_res;
            for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign result = r_pipe[LAT-1];
endmodule

module FloatComparator_64 #(
    parameter int LAT = 1
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [63:0] dataa,
    input  logic [63:0] datab,
    output logic        agb,
    output logic        alb
);
    // map sign-magnitude onto an unsigned key with the same ordering
    function automatic logic [63:0] f_key(input logic [63:0] x);
        return x[63] ? ~x : {1'b1, x[62:0]};
    endfunction

    logic [LAT-1:0][1:0] r_pipe;

    // flag pipeline: {a>b, a<b}
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) r_pipe <= '0;
        else if (clk_en) begin
            r_pipe[0] <= {f_key(dataa) > f_key(datab), f_key(dataa) < f_key(datab)};
            for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign agb = r_pipe[LAT-1][1];
    assign alb = r_pipe[LAT-1][0];
endmodule

// File: rtl/pi_controller64_water.sv
// pi_controller64_water: discrete PI regulator, integ += ki_ts*e; u = kp*e + integ.
// Sequences shared double multipliers/adder through an FSM paced by pi_latency_cnt.
// Optional PI_INTEG_CLAMP_EN: anti-windup clamp of integ to [integ_lo, integ_hi].
module pi_controller64_water
    import pi_controller64_water_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int ADD_LAT = ADD_LAT_DEF,
    parameter int CMP_LAT = CMP_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sta,
    input  logic                        init,
    input  logic [`EXTENDED_SINGLE-1:0] init_val,
    input  logic [`EXTENDED_SINGLE-1:0] kp,
    input  logic [`EXTENDED_SINGLE-1:0] ki_ts,
    input  logic [`EXTENDED_SINGLE-1:0] e,
    input  logic [`EXTENDED_SINGLE-1:0] integ_hi,
    input  logic [`EXTENDED_SINGLE-1:0] integ_lo,
    output logic [`EXTENDED_SINGLE-1:0] u,
    output logic [`EXTENDED_SINGLE-1:0] integ,
    output logic                        busy,
    output logic                        done_sig
);
    pi_state_e r_state, w_next;
    logic [`EXTENDED_SINGLE-1:0] r_kp, r_ki_ts, r_e, r_integ, r_u;
    logic [`EXTENDED_SINGLE-1:0] w_mul_kp_a, w_mul_ki_a, w_mul_e, w_mul_kp, w_mul_ki;
    logic [`EXTENDED_SINGLE-1:0] w_add_a, w_add_b, w_add_res, w_integ_new, w_integ_d;
    logic                        r_done;
    logic                        w_idle, w_accept, w_preload, w_load, w_tc, w_integ_wr, w_aclr;
    logic [CNT_W-1:0]            w_load_val;

    assign w_aclr    = ~rst;
    // the done cycle still counts as busy, so nothing is accepted there
    assign w_idle    = (r_state == PI_ST_IDLE) && !r_done;
    assign w_preload = w_idle && init;
    assign w_accept  = w_idle && sta && !init;

    // next-state sequencing: each latency state holds until the counter's terminal count
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_integ_wr = 1'b0;
        case (r_state)
            PI_ST_IDLE: if (w_accept) begin
                w_next = PI_ST_MUL; w_load = 1'b1; w_load_val = lat_reload(MUL_LAT);
            end
            PI_ST_MUL: if (w_tc) begin
                w_next = PI_ST_ADD_I; w_load = 1'b1; w_load_val = lat_reload(ADD_LAT);
            end
            PI_ST_ADD_I: if (w_tc) begin
`ifdef PI_INTEG_CLAMP_EN
                w_next = PI_ST_CLAMP; w_load = 1'b1; w_load_val = lat_reload(CMP_LAT + 1);
`else
                w_next = PI_ST_ADD_U; w_load = 1'b1; w_load_val = lat_reload(ADD_LAT);
                w_integ_wr = 1'b1;
`endif
            end
`ifdef PI_INTEG_CLAMP_EN
            PI_ST_CLAMP: if (w_tc) begin
                w_next = PI_ST_ADD_U; w_load = 1'b1; w_load_val = lat_reload(ADD_LAT);
                w_integ_wr = 1'b1;
            end
`endif
            PI_ST_ADD_U: if (w_tc) w_next = PI_ST_DONE;
            PI_ST_DONE:  w_next = PI_ST_IDLE;
            default:     w_next = PI_ST_IDLE;
        endcase
    end

`ifdef PI_INTEG_CLAMP_EN
    logic w_cmp_gt, w_cmp_lt, w_hi_alb_unused, w_lo_agb_unused;
    FloatComparator_64 #(.LAT(CMP_LAT)) u_cmp_hi (
        .clock(clk), .aclr(w_aclr), .clk_en(`ENA_MATH),
        .dataa(w_add_res), .datab(integ_hi), .agb(w_cmp_gt), .alb(w_hi_alb_unused));
    FloatComparator_64 #(.LAT(CMP_LAT)) u_cmp_lo (
        .clock(clk), .aclr(w_aclr), .clk_en(`ENA_MATH),
        .dataa(w_add_res), .datab(integ_lo), .agb(w_lo_agb_unused), .alb(w_cmp_lt));
`else
    logic w_unused;
    assign w_unused = ^{integ_hi, integ_lo, 32'(CMP_LAT)};
`endif

    // operands follow the next state so each core samples them on the state-entry edge
    always_comb begin
        w_mul_kp_a = w_accept ? kp    : r_kp;
        w_mul_ki_a = w_accept ? ki_ts : r_ki_ts;
        w_mul_e    = w_accept ? e     : r_e;
`ifdef PI_INTEG_CLAMP_EN
        w_integ_new = w_cmp_gt ? integ_hi : (w_cmp_lt ? integ_lo : w_add_res);
`else
        w_integ_new = w_add_res;
`endif
        w_integ_d = w_integ_wr ? w_integ_new : r_integ;
        w_add_a   = r_integ;
        w_add_b   = w_mul_ki;
        if (w_next == PI_ST_ADD_U || w_next == PI_ST_DONE) begin
            w_add_a = w_mul_kp;
            w_add_b = w_integ_d;
        end
    end

    pi_latency_cnt #(.W(CNT_W)) u_cnt (
        .i_clk(clk), .i_rst_n(rst), .i_load(w_load), .i_load_val(w_load_val), .o_tc(w_tc));

    FloatMult_64 #(.LAT(MUL_LAT)) u_mul_kp (
        .clock(clk), .aclr(w_aclr), .clk_en(`ENA_MATH),
        .dataa(w_mul_kp_a), .datab(w_mul_e), .result(w_mul_kp));
    FloatMult_64 #(.LAT(MUL_LAT)) u_mul_ki (
        .clock(clk), .aclr(w_aclr), .clk_en(`ENA_MATH),
        .dataa(w_mul_ki_a), .datab(w_mul_e), .result(w_mul_ki));
    FloatAddSub_64 #(.LAT(ADD_LAT)) u_add (
        .clock(clk), .aclr(w_aclr), .clk_en(`ENA_MATH), .add_sub(1'b1),
        .dataa(w_add_a), .datab(w_add_b), .result(w_add_res));

    // state, captured operands, integrator and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= PI_ST_IDLE;
            r_done  <= 1'b0;
            r_kp    <= '0;
            r_ki_ts <= '0;
            r_e     <= '0;
            r_integ <= '0;
            r_u     <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == PI_ST_DONE);
            if (w_accept) begin
                r_kp    <= kp;
                r_ki_ts <= ki_ts;
                r_e     <= e;
            end
            if (w_integ_wr)     r_integ <= w_integ_new;
            else if (w_preload) r_integ <= init_val;
            if (r_state == PI_ST_DONE) r_u <= w_add_res;
        end
    end

    assign u        = r_u;
    assign integ    = r_integ;
    assign done_sig = r_done;
    assign busy     = (r_state != PI_ST_IDLE) || r_done;
endmodule

// File: tb/tb_pi_controller64_water.sv
// Randomized self-checking bench for pi_controller64_water against a real-arithmetic model.
// Random operands are small dyadic values so every product and sum is exact in double.
module tb_pi_controller64_water;
    logic        clk, rst, sta, init, busy, done_sig;
    logic [63:0] init_val, kp, ki_ts, e, integ_hi, integ_lo, u, integ;
    int          n_chk, n_fail;
    real         m_integ, m_u;
`ifdef PI_INTEG_CLAMP_EN
    localparam int EXP_LAT = 24;
`else
    localparam int EXP_LAT = 22;
`endif

    pi_controller64_water dut (
        .clk(clk), .rst(rst), .sta(sta), .init(init), .init_val(init_val),
        .kp(kp), .ki_ts(ki_ts), .e(e), .integ_hi(integ_hi), .integ_lo(integ_lo),
        .u(u), .integ(integ), .busy(busy), .done_sig(done_sig));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd_val();
        real v;
        int  k;
        v = real'($urandom_range(15, 1));
        k = int'($urandom_range(6, 0));
        for (int i = 0; i < k; i++) v = v * 2.0;
        v = v / 8.0;
        if ($urandom_range(1, 0) == 1) v = -v;
        return $realtobits(v);
    endfunction

    // specification-level update rule
    task automatic model_step(input logic [63:0] a_kp, input logic [63:0] a_ki, input logic [63:0] a_e);
        m_integ = m_integ + $bitstoreal(a_ki) * $bitstoreal(a_e);
`ifdef PI_INTEG_CLAMP_EN
        if (m_integ > $bitstoreal(integ_hi))      m_integ = $bitstoreal(integ_hi);
        else if (m_integ < $bitstoreal(integ_lo)) m_integ = $bitstoreal(integ_lo);
`endif
        m_u = $bitstoreal(a_kp) * $bitstoreal(a_e) + m_integ;
    endtask

    task automatic count_done(input int cycles, input string tag);
        int nd;
        nd = 0;
        repeat (cycles) begin
            tick();
            if (done_sig) nd++;
        end
        check(tag, 64'(nd), 64'd0);
    endtask

    // one sta; optional stray sta pulses at +3/+10; operands scrambled after acceptance
    task automatic do_update(input logic [63:0] a_kp, input logic [63:0] a_ki,
                             input logic [63:0] a_e, input bit glitch);
        int lat, nbusy;
        kp = a_kp; ki_ts = a_ki; e = a_e; sta = 1'b1;
        tick();
        sta = 1'b0; kp = rnd_val(); ki_ts = rnd_val(); e = rnd_val();
        lat = 1; nbusy = 0;
        while (!done_sig && lat < 200) begin
            if (busy) nbusy++;
            sta = glitch && (lat == 3 || lat == 10);
            tick();
            lat++;
        end
        sta = 1'b0;
        if (busy) nbusy++;
        check("latency", 64'(lat), 64'(EXP_LAT));
        check("busy_cycles", 64'(nbusy), 64'(EXP_LAT));
        model_step(a_kp, a_ki, a_e);
        check("integ", integ, $realtobits(m_integ));
        check("u", u, $realtobits(m_u));
        tick();
        check("done_pulse_width", 64'(done_sig), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        count_done(30, "extra_done");
    endtask

    initial begin
        logic [63:0] v;
        n_chk = 0; n_fail = 0; m_integ = 0.0; m_u = 0.0;
        sta = 1'b0; init = 1'b0; init_val = '0; kp = '0; ki_ts = '0; e = '0;
        integ_hi = $realtobits(1.0e30);
        integ_lo = $realtobits(-1.0e30);
        rst = 1'b1;
        #2 rst = 1'b0;
        #10;
        check("rst_u", u, 64'd0);
        check("rst_integ", integ, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done_sig), 64'd0);
        rst = 1'b1;
        tick(); tick();

        // directed: two identical updates from zero
        do_update(64'h4000000000000000, 64'h3FE0000000000000, 64'h3FF0000000000000, 1'b0);
        check("dir1_integ", integ, 64'h3FE0000000000000);
        check("dir1_u", u, 64'h4004000000000000);
        do_update(64'h4000000000000000, 64'h3FE0000000000000, 64'h3FF0000000000000, 1'b0);
        check("dir2_integ", integ, 64'h3FF0000000000000);
        check("dir2_u", u, 64'h4008000000000000);

        // preload -2.0 then update
        init = 1'b1; init_val = 64'hC000000000000000;
        tick();
        init = 1'b0;
        check("preload_integ", integ, 64'hC000000000000000);
        check("preload_no_done", 64'(done_sig), 64'd0);
        m_integ = -2.0;
        do_update(64'h4000000000000000, 64'h3FE0000000000000, 64'h3FF0000000000000, 1'b0);
        check("dir3_integ", integ, 64'hBFF8000000000000);
        check("dir3_u", u, 64'h3FE0000000000000);

        // stray sta while busy
        do_update(rnd_val(), rnd_val(), rnd_val(), 1'b1);

        // init and sta together: only the preload happens
        v = rnd_val();
        init = 1'b1; sta = 1'b1; init_val = v; kp = rnd_val(); ki_ts = rnd_val(); e = rnd_val();
        tick();
        init = 1'b0; sta = 1'b0;
        check("init_sta_integ", integ, v);
        check("init_sta_busy", 64'(busy), 64'd0);
        m_integ = $bitstoreal(v);
        count_done(30, "init_sta_done");

        // reset in the middle of an update
        kp = rnd_val(); ki_ts = rnd_val(); e = rnd_val(); sta = 1'b1;
        tick();
        sta = 1'b0;
        repeat (7) tick();
        rst = 1'b0;
        #1;
        check("midrst_u", u, 64'd0);
        check("midrst_integ", integ, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done_sig), 64'd0);
        m_integ = 0.0; m_u = 0.0;
        tick(); tick();
        rst = 1'b1;
        count_done(30, "midrst_no_done");
        do_update(rnd_val(), rnd_val(), rnd_val(), 1'b0);

`ifdef PI_INTEG_CLAMP_EN
        // anti-windup: integrator held at the upper bound
        init = 1'b1; init_val = 64'h3FF0000000000000;
        tick();
        init = 1'b0;
        m_integ = 1.0;
        integ_hi = 64'h3FF0000000000000;
        do_update(64'h4000000000000000, 64'h3FE0000000000000, 64'h3FF0000000000000, 1'b0);
        check("clamp_integ", integ, 64'h3FF0000000000000);
        check("clamp_u", u, 64'h4008000000000000);
        integ_hi = $realtobits(1.0e30);
`endif

        // randomized updates with occasional preloads
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(3, 0) == 0) begin
                v = rnd_val();
                init = 1'b1; init_val = v;
                tick();
                init = 1'b0;
                m_integ = $bitstoreal(v);
                check("rnd_preload", integ, v);
            end
            do_update(rnd_val(), rnd_val(), rnd_val(), ($urandom_range(3, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
